// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: the pipeline drives the MEM-stage controls and operands,
// and the stage returns the writeback, forwarding, status and debug signals.
interface mem_wb_stage_if;
    logic        halt_i;
    logic [4:0]  rw_i;
    logic        jal_i;
    logic        Memwrite_i;
    logic        MemToReg_i;
    logic        Regwrite_i;
    logic        RegDst_i;
    logic        lb_i;
    logic        lui_i;
    logic [31:0] B_i;
    logic [31:0] Imm_i;
    logic [31:0] PC_i;
    logic [31:0] ALU_i;
    logic [9:0]  dbg_addr_i;

    logic [31:0] wb_data_o;
    logic [4:0]  wb_rw_o;
    logic        wb_we_o;
    logic [31:0] fwd_data_o;
    logic        halted_o;
    logic [15:0] load_cnt_o;
    logic [15:0] store_cnt_o;
    logic [31:0] dbg_data_o;

    modport master (
        output halt_i, rw_i, jal_i, Memwrite_i, MemToReg_i, Regwrite_i, RegDst_i,
               lb_i, lui_i, B_i, Imm_i, PC_i, ALU_i, dbg_addr_i,
        input  wb_data_o, wb_rw_o, wb_we_o, fwd_data_o, halted_o,
               load_cnt_o, store_cnt_o, dbg_data_o
    );

    modport slave (
        input  halt_i, rw_i, jal_i, Memwrite_i, MemToReg_i, Regwrite_i, RegDst_i,
               lb_i, lui_i, B_i, Imm_i, PC_i, ALU_i, dbg_addr_i,
        output wb_data_o, wb_rw_o, wb_we_o, fwd_data_o, halted_o,
               load_cnt_o, store_cnt_o, dbg_data_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 1024x32 data RAM, load byte extraction, result select
// for forwarding, registered writeback, sticky halt and load/store counters.
module mem_wb_stage (
    input logic         clk,
    input logic         rst,
    mem_wb_stage_if.slave bus
);
    logic [31:0] ram [0:1023];
    logic [9:0]  word_addr;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;
    logic [31:0] fwd_data;
    logic        mem_write_en;

    logic [31:0] wb_data;
    logic [4:0]  wb_rw;
    logic        wb_we;
    logic        halted;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    logic        unused_ok;

    assign word_addr = bus.ALU_i[11:2];
    assign rd_word   = ram[word_addr];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (bus.ALU_i[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
        endcase
    end

    assign load_data = bus.lb_i ? {{24{rd_byte[7]}}, rd_byte} : rd_word;

    always_comb begin
        fwd_data = bus.ALU_i;
        if (bus.jal_i)
            fwd_data = bus.PC_i + 32'd1;
        else if (bus.lui_i)
            fwd_data = {bus.Imm_i[15:0], 16'h0000};
        else if (bus.MemToReg_i)
            fwd_data = load_data;
    end

    // A store issued alongside halt_i still lands; only later cycles are blocked.
    assign mem_write_en = bus.Memwrite_i && !halted && !rst;

    // RAM has no reset: contents survive rst so a halted program can be inspected.
    always_ff @(posedge clk) begin
        if (mem_write_en)
            ram[word_addr] <= bus.B_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data   <= 32'd0;
            wb_rw     <= 5'd0;
            wb_we     <= 1'b0;
            halted    <= 1'b0;
            load_cnt  <= 16'd0;
            store_cnt <= 16'd0;
        end else if (!halted) begin
            wb_data <= fwd_data;
            wb_rw   <= bus.rw_i;
            wb_we   <= bus.Regwrite_i && (bus.rw_i != 5'd0);
            if (bus.MemToReg_i && (load_cnt != 16'hFFFF))
                load_cnt <= load_cnt + 16'd1;
            if (bus.Memwrite_i && (store_cnt != 16'hFFFF))
                store_cnt <= store_cnt + 16'd1;
            if (bus.halt_i)
                halted <= 1'b1;
        end else begin
            wb_we <= 1'b0;
        end
    end

    assign bus.wb_data_o   = wb_data;
    assign bus.wb_rw_o     = wb_rw;
    assign bus.wb_we_o     = wb_we;
    assign bus.fwd_data_o  = fwd_data;
    assign bus.halted_o    = halted;
    assign bus.load_cnt_o  = load_cnt;
    assign bus.store_cnt_o = store_cnt;
    assign bus.dbg_data_o  = ram[bus.dbg_addr_i];

    // RegDst and the unused operand bits are accepted but have no function here.
    assign unused_ok = ^{bus.RegDst_i, bus.Imm_i[31:16], bus.ALU_i[31:12]};
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage; a behavioural model predicts
// each cycle's registered outputs and a monitor compares them after the edge.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst;

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        halt;
        bit        jal;
        bit        mw;
        bit        m2r;
        bit        rwe;
        bit        rdst;
        bit        lb;
        bit        lui;
        bit [4:0]  rw;
        bit [31:0] b;
        bit [31:0] imm;
        bit [31:0] pc;
        bit [31:0] alu;
        bit [9:0]  dbg;
    } stim_t;

    typedef struct {
        bit [31:0] data;
        bit        data_known;
        bit [4:0]  rw;
        bit        we;
        bit        halted;
        int        lcnt;
        int        scnt;
        bit [31:0] dbg;
        bit        dbg_known;
    } exp_t;

    exp_t      exp_q[$];
    bit [31:0] mram[int];
    exp_t      m;
    int        n_checks = 0;
    int        n_pass = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit [31:0] model_load(bit [31:0] word, bit lb, bit [1:0] sel);
        int v;
        if (!lb)
            return word;
        v = (word >> (8 * sel)) & 255;
        if (v >= 128)
            v = v - 256;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
    endtask

    task automatic drive(input stim_t s);
        rst            = s.rst;
        bus.halt_i     = s.halt;
        bus.jal_i      = s.jal;
        bus.Memwrite_i = s.mw;
        bus.MemToReg_i = s.m2r;
        bus.Regwrite_i = s.rwe;
        bus.RegDst_i   = s.rdst;
        bus.lb_i       = s.lb;
        bus.lui_i      = s.lui;
        bus.rw_i       = s.rw;
        bus.B_i        = s.b;
        bus.Imm_i      = s.imm;
        bus.PC_i       = s.pc;
        bus.ALU_i      = s.alu;
        bus.dbg_addr_i = s.dbg;
    endtask

    // Drive one cycle, check the combinational result, then advance the model.
    task automatic apply_stimulus(input stim_t s);
        int        wa;
        bit [31:0] fwd;
        bit        fwd_known;
        @(negedge clk);
        drive(s);
        wa = int'(s.alu[11:2]);
        fwd_known = 1'b1;
        if (s.jal)
            fwd = s.pc + 32'd1;
        else if (s.lui)
            fwd = {s.imm[15:0], 16'h0000};
        else if (s.m2r) begin
            fwd_known = mram.exists(wa);
            fwd = fwd_known ? model_load(mram[wa], s.lb, s.alu[1:0]) : 32'd0;
        end else
            fwd = s.alu;
        #1;
        if (fwd_known)
            check_output("fwd_data", bus.fwd_data_o, fwd);

        if (s.rst) begin
            m = '{default: 0};
            m.data_known = 1'b1;
        end else if (!m.halted) begin
            m.data       = fwd;
            m.data_known = fwd_known;
            m.rw         = s.rw;
            m.we         = s.rwe && (s.rw != 5'd0);
            if (s.m2r)
                m.lcnt = (m.lcnt < 65535) ? m.lcnt + 1 : 65535;
            if (s.mw) begin
                m.scnt = (m.scnt < 65535) ? m.scnt + 1 : 65535;
                mram[wa] = s.b;
            end
            if (s.halt)
                m.halted = 1'b1;
        end else begin
            m.we = 1'b0;
        end
        m.dbg_known = mram.exists(int'(s.dbg));
        m.dbg = m.dbg_known ? mram[int'(s.dbg)] : 32'd0;
        exp_q.push_back(m);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.data_known)
                    check_output("wb_data", bus.wb_data_o, e.data);
                check_output("wb_rw", bus.wb_rw_o, e.rw);
                check_output("wb_we", bus.wb_we_o, e.we);
                check_output("halted", bus.halted_o, e.halted);
                check_output("load_cnt", bus.load_cnt_o, e.lcnt);
                check_output("store_cnt", bus.store_cnt_o, e.scnt);
                if (e.dbg_known)
                    check_output("dbg_data", bus.dbg_data_o, e.dbg);
            end
        end
    end

    initial begin
        stim_t s;
        m = '{default: 0};
        s = idle();
        s.rst = 1'b1;
        drive(s);
        apply_stimulus(s);
        apply_stimulus(s);

        for (int w = 0; w < 16; w++) begin
            s = idle();
            s.mw  = 1'b1;
            s.alu = w << 2;
            s.b   = $urandom;
            s.dbg = 10'(w);
            apply_stimulus(s);
        end

        // Byte and word loads from a known pattern.
        s = idle();
        s.mw = 1'b1; s.alu = 32'h10; s.b = 32'h8081_82F3; s.dbg = 10'd4;
        apply_stimulus(s);
        s = idle();
        s.m2r = 1'b1; s.lb = 1'b1; s.rwe = 1'b1; s.rw = 5'd5; s.alu = 32'h10;
        apply_stimulus(s);
        s.alu = 32'h13;
        apply_stimulus(s);
        s.lb = 1'b0; s.alu = 32'h10;
        apply_stimulus(s);

        s = idle();
        s.jal = 1'b1; s.pc = 32'h40; s.rw = 5'd31; s.rwe = 1'b1;
        apply_stimulus(s);
        s = idle();
        s.lui = 1'b1; s.imm = 32'h1234; s.rw = 5'd7; s.rwe = 1'b1;
        apply_stimulus(s);
        s = idle();
        s.rwe = 1'b1; s.rw = 5'd0; s.alu = 32'hDEAD_BEEF;
        apply_stimulus(s);

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 39) == 0);
            s.jal  = ($urandom_range(0, 7) == 0);
            s.lui  = ($urandom_range(0, 7) == 0);
            s.mw   = $urandom_range(0, 1);
            s.m2r  = $urandom_range(0, 1);
            s.rwe  = $urandom_range(0, 1);
            s.rdst = $urandom_range(0, 1);
            s.lb   = $urandom_range(0, 1);
            s.rw   = 5'($urandom_range(0, 31));
            s.b    = $urandom;
            s.imm  = $urandom;
            s.pc   = $urandom;
            s.alu  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            s.dbg  = 10'($urandom_range(0, 15));
            apply_stimulus(s);
        end

        // Counter accumulation, then saturation at the top.
        s = idle();
        s.rst = 1'b1;
        apply_stimulus(s);
        for (int i = 0; i < 5; i++) begin
            s = idle();
            s.alu = 32'h24;
            s.b   = $urandom;
            if (i < 3) s.m2r = 1'b1;
            else       s.mw  = 1'b1;
            apply_stimulus(s);
        end
        for (int i = 0; i < 65540; i++) begin
            s = idle();
            s.m2r = 1'b1; s.mw = 1'b1; s.alu = 32'h3C; s.b = $urandom; s.dbg = 10'd15;
            apply_stimulus(s);
        end

        // Halt: a store in the halt cycle lands, later stores are blocked.
        s = idle();
        s.rst = 1'b1;
        apply_stimulus(s);
        s = idle();
        s.mw = 1'b1; s.alu = 32'h20; s.b = 32'h1111_2222; s.dbg = 10'd8;
        apply_stimulus(s);
        s.halt = 1'b1; s.b = 32'h3333_4444; s.rwe = 1'b1; s.rw = 5'd9;
        apply_stimulus(s);
        for (int i = 0; i < 4; i++) begin
            s = idle();
            s.mw = 1'b1; s.m2r = 1'b1; s.rwe = 1'b1; s.rw = 5'd3;
            s.alu = 32'h20; s.b = $urandom; s.dbg = 10'd8;
            apply_stimulus(s);
        end
        s = idle();
        s.rst = 1'b1; s.mw = 1'b1; s.alu = 32'h20; s.b = 32'h5555_6666; s.dbg = 10'd8;
        apply_stimulus(s);
        s = idle();
        s.rwe = 1'b1; s.rw = 5'd4; s.alu = 32'h77; s.dbg = 10'd8;
        apply_stimulus(s);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain: pending %0d, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
